// File: rtl/add_with_carry_32bit.sv
// Registered 32-bit add-with-carry: {cout, sum} = a + b + cin, 1-cycle latency.
// Define ADD_WITH_CARRY_FLAGS_EN to add registered ovf/zero/neg status flags.
module add_with_carry_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
`ifdef ADD_WITH_CARRY_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero,
    output logic             neg
`endif
);

    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    // Zero-extend before adding so bit WIDTH keeps the true carry-out.
    always_comb begin
        wide   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sum_d  = wide[WIDTH-1:0];
        cout_d = wide[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_d;
                cout <= cout_d;
            end
        end
    end

`ifdef ADD_WITH_CARRY_FLAGS_EN
    logic ovf_d;
    logic zero_d;
    logic neg_d;

    always_comb begin
        ovf_d  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_d[WIDTH-1] != a[WIDTH-1]);
        zero_d = (sum_d == '0);
        neg_d  = sum_d[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf  <= 1'b0;
            zero <= 1'b0;
            neg  <= 1'b0;
        end else if (in_valid) begin
            ovf  <= ovf_d;
            zero <= zero_d;
            neg  <= neg_d;
        end
    end
`endif

endmodule

// File: tb/tb_add_with_carry_32bit.sv
// Directed and random self-checking bench for add_with_carry_32bit.
module tb_add_with_carry_32bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        out_valid;
`ifdef ADD_WITH_CARRY_FLAGS_EN
    logic        ovf;
    logic        zero;
    logic        neg;
`endif

    int checks = 0;
    int errors = 0;

    add_with_carry_32bit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
`ifdef ADD_WITH_CARRY_FLAGS_EN
        ,
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] aa,
                         input logic [31:0] bb, input logic c);
        rst      = r;
        in_valid = v;
        a        = aa;
        b        = bb;
        cin      = c;
    endtask

    task automatic chk(input string tag, input logic ev, input logic ec,
                       input logic [31:0] es);
        checks++;
        assert ({out_valid, cout, sum} === {ev, ec, es}) else begin
            errors++;
            $error("FAIL %s: valid/cout/sum got %b/%b/%h expected %b/%b/%h",
                   tag, out_valid, cout, sum, ev, ec, es);
        end
    endtask

    task automatic chk_flags(input string tag, input logic eo, input logic ez,
                             input logic en);
`ifdef ADD_WITH_CARRY_FLAGS_EN
        checks++;
        assert ({ovf, zero, neg} === {eo, ez, en}) else begin
            errors++;
            $error("FAIL %s: ovf/zero/neg got %b%b%b expected %b%b%b",
                   tag, ovf, zero, neg, eo, ez, en);
        end
`else
        if (tag.len() < 0) checks++;
`endif
    endtask

    logic [32:0] ref_w;
    logic        m_v;
    logic        m_c;
    logic [31:0] m_s;
    logic        m_o;
    logic        m_z;
    logic        m_n;

    initial begin
        drive(1'b1, 1'b1, 32'h12345678, 32'h0, 1'b0);
        tick;
        chk("reset1", 1'b0, 1'b0, 32'h0);
        chk_flags("reset1_f", 1'b0, 1'b0, 1'b0);
        tick;
        chk("reset2", 1'b0, 1'b0, 32'h0);
        chk_flags("reset2_f", 1'b0, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
        tick;
        chk("zero_cin", 1'b1, 1'b0, 32'h00000001);
        chk_flags("zero_cin_f", 1'b0, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 32'h12345678, 32'h87654321, 1'b0);
        tick;
        chk("mixed", 1'b1, 1'b0, 32'h99999999);
        chk_flags("mixed_f", 1'b0, 1'b0, 1'b1);

        drive(1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b1);
        tick;
        chk("wrap_cin1", 1'b1, 1'b1, 32'h00000001);
        chk_flags("wrap_cin1_f", 1'b0, 1'b0, 1'b0);

        drive(1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        tick;
        chk("wrap_b1", 1'b1, 1'b1, 32'h0);
        chk_flags("wrap_b1_f", 1'b0, 1'b1, 1'b0);

        drive(1'b0, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b1);
        tick;
        chk("wrap_cin_only", 1'b1, 1'b1, 32'h0);
        chk_flags("wrap_cin_only_f", 1'b0, 1'b1, 1'b0);

        drive(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        tick;
        chk("all_ones", 1'b1, 1'b1, 32'hFFFFFFFF);
        chk_flags("all_ones_f", 1'b0, 1'b0, 1'b1);

        drive(1'b0, 1'b1, 32'h0000FFFF, 32'h0, 1'b1);
        tick;
        chk("chain", 1'b1, 1'b0, 32'h00010000);

        drive(1'b0, 1'b1, 32'h7FFFFFFF, 32'h0, 1'b1);
        tick;
        chk("ovf", 1'b1, 1'b0, 32'h80000000);
        chk_flags("ovf_f", 1'b1, 1'b0, 1'b1);

        drive(1'b0, 1'b0, 32'h11111111, 32'h22222222, 1'b1);
        tick;
        chk("hold", 1'b0, 1'b0, 32'h80000000);
        chk_flags("hold_f", 1'b1, 1'b0, 1'b1);

        drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
        tick;
        chk("b2b_1", 1'b1, 1'b0, 32'h00000001);
        drive(1'b0, 1'b1, 32'h12345678, 32'h87654321, 1'b0);
        tick;
        chk("b2b_2", 1'b1, 1'b0, 32'h99999999);
        drive(1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b1);
        tick;
        chk("b2b_3", 1'b1, 1'b1, 32'h00000001);
        drive(1'b1, 1'b1, 32'h7FFFFFFF, 32'h0, 1'b1);
        tick;
        chk("b2b_rst", 1'b0, 1'b0, 32'h0);
        chk_flags("b2b_rst_f", 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h00000005, 32'h00000007, 1'b1);
        tick;
        chk("resume", 1'b1, 1'b0, 32'h0000000D);

        m_v = 1'b1;
        m_c = 1'b0;
        m_s = 32'h0000000D;
        m_o = 1'b0;
        m_z = 1'b0;
        m_n = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  $urandom, $urandom, 1'($urandom_range(0, 1)));
            if (i % 500 == 0) a = 32'hFFFFFFFF;
            ref_w = {1'b0, a} + {1'b0, b} + {32'h0, cin};
            if (rst) begin
                m_v = 1'b0;
                m_c = 1'b0;
                m_s = 32'h0;
                m_o = 1'b0;
                m_z = 1'b0;
                m_n = 1'b0;
            end else if (in_valid) begin
                m_v = 1'b1;
                m_c = ref_w[32];
                m_s = ref_w[31:0];
                m_o = (a[31] == b[31]) && (ref_w[31] != a[31]);
                m_z = (ref_w[31:0] == 32'h0);
                m_n = ref_w[31];
            end else begin
                m_v = 1'b0;
            end
            tick;
            chk("random", m_v, m_c, m_s);
            chk_flags("random_f", m_o, m_z, m_n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
